// File: rtl/af_pkg.sv
// af_pkg: shared constants, select encodings and FSM states for the activation scheduler
package af_pkg;
    localparam logic [15:0] ONE = 16'h0400;
    localparam logic [1:0] SEL_SIGMOID = 2'b00;
    localparam logic [1:0] SEL_TANH = 2'b01;
    localparam logic [1:0] SEL_RELU = 2'b10;
    localparam logic [1:0] SEL_IDENT = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/af_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);
    // scan from farthest to nearest so the request closest to ptr wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                idx = ID_W'((int'(ptr) + k) % N_REQ);
                any = 1'b1;
            end
        end
        gnt = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/af_scheduler.sv
// af_scheduler: round-robin sharing of one activation unit; AF_RELU_BYPASS_EN computes relu/identity locally
module af_scheduler #(
    parameter int WIDTH = 15,
    parameter int N_REQ = 4,
    parameter int ID_W = 2
) (
    input  logic                     clk,
    input  logic                     ext_reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*(WIDTH+1)-1:0] req_z,
    input  logic [2*N_REQ-1:0]       req_sel,
    output logic [N_REQ-1:0]         gnt,
    output logic                     au_start,
    output logic [WIDTH:0]           au_z,
    output logic [1:0]               au_sel,
    input  logic                     au_done,
    input  logic [WIDTH:0]           au_f,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH:0]           rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);
    import af_pkg::*;

    state_t           state;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  nxt;
    logic [N_REQ-1:0] arb_gnt;
    logic             any;
    logic [WIDTH:0]   sel_z;
    logic [1:0]       sel_s;
    logic             byp;
    logic [WIDTH:0]   byp_f;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req(req),
        .ptr(ptr),
        .gnt(arb_gnt),
        .idx(idx),
        .any(any)
    );

    assign sel_z = req_z[int'(idx)*(WIDTH+1) +: WIDTH+1];
    assign sel_s = req_sel[2*int'(idx) +: 2];
    assign nxt = (int'(idx) == N_REQ - 1) ? '0 : idx + 1'b1;
    assign byp_f = (sel_s == SEL_RELU && sel_z[WIDTH]) ? '0 : sel_z;
`ifdef AF_RELU_BYPASS_EN
    assign byp = sel_s[1];
`else
    assign byp = 1'b0;
`endif

    // grant is the acceptance pulse of the IDLE edge, so it must be visible in that same cycle
    assign gnt = (state == IDLE && !ext_reset) ? arb_gnt : '0;

    // scheduler FSM with registered operand and response outputs
    always_ff @(posedge clk) begin
        if (ext_reset) begin
            state     <= IDLE;
            ptr       <= '0;
            au_start  <= 1'b0;
            au_z      <= '0;
            au_sel    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (any) begin
                    au_z   <= sel_z;
                    au_sel <= sel_s;
                    rsp_id <= idx;
                    ptr    <= nxt;
                    busy   <= 1'b1;
                    if (byp) begin
                        rsp_data  <= byp_f;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        au_start <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    au_start <= 1'b0;
                    state    <= WAIT;
                end
                WAIT: if (au_done) begin
                    rsp_data  <= au_f;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_af_scheduler.sv
// tb_af_scheduler: vector table, corner sequences and randomized scoreboard for af_scheduler
module tb_af_scheduler;
    logic        clk = 0, ext_reset = 1, rsp_ready = 0;
    logic [3:0]  req = 0;
    logic [63:0] req_z = 0;
    logic [7:0]  req_sel = 0;
    logic [3:0]  gnt;
    logic        au_start, au_done, rsp_valid, busy;
    logic [15:0] au_z, au_f, rsp_data;
    logic [1:0]  au_sel, rsp_id;

    logic        m_done = 0, man_done = 0;
    logic [15:0] m_z = 0, man_f = 0;
    logic [1:0]  m_sel = 0;
    int cnt = 0, hcnt = 0, au_lat = 20, au_hold = 2, n_start = 0, n_tests = 0, n_fail = 0;

    typedef struct { logic [3:0] req; logic [15:0] z; logic [1:0] sel; int id; } vec_t;
    typedef struct { int id; logic [15:0] z; logic [1:0] sel; } op_t;
    vec_t tbl[13];
    op_t  q[$];
    bit   pend[4];
    logic [15:0] pz[4];
    logic [1:0]  ps[4];
    bit   m_busy = 0;
    int   m_ptr = 0, n_nb = 0;

    function automatic logic [15:0] fn(input logic [15:0] z, input logic [1:0] s);
        return (z == 16'h0400 && s == 2'b00) ? 16'h02EC : z ^ 16'h5A5A ^ {14'd0, s};
    endfunction

    function automatic bit byp(input logic [1:0] s);
`ifdef AF_RELU_BYPASS_EN
        return s[1];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [15:0] exp_f(input logic [15:0] z, input logic [1:0] s);
        if (byp(s)) return (s == 2'b10 && z[15]) ? 16'h0000 : z;
        return fn(z, s);
    endfunction

    assign au_done = m_done | man_done;
    assign au_f = m_done ? fn(m_z, m_sel) : man_f;

    always #5 clk = ~clk;

    af_scheduler #(.WIDTH(15), .N_REQ(4), .ID_W(2)) dut (
        .clk(clk), .ext_reset(ext_reset), .req(req), .req_z(req_z), .req_sel(req_sel),
        .gnt(gnt), .au_start(au_start), .au_z(au_z), .au_sel(au_sel),
        .au_done(au_done), .au_f(au_f), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // one cycle; the activation unit model reacts to au_start with au_lat cycles latency
    task automatic step;
        @(negedge clk);
        if (au_start) begin
            cnt = au_lat; m_z = au_z; m_sel = au_sel; m_done = 0; n_start++;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin m_done = 1; hcnt = au_hold; end
        end else if (m_done) begin
            hcnt--;
            if (hcnt == 0) m_done = 0;
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [15:0] z, input logic [1:0] s, input int id);
        req = r;
        for (int i = 0; i < 4; i++) req_z[i*16 +: 16] = (i == id) ? z : ~z;
        req_sel = {4{s}};
    endtask

    task automatic wait_rsp;
        int t = 0;
        while (!rsp_valid && t < 200) begin step; t++; end
        if (!rsp_valid) flag("rsp_timeout");
    endtask

    task automatic run_op(input logic [3:0] r, input logic [15:0] z, input logic [1:0] s, input int id, input int hold);
        int ns;
        logic [15:0] ex;
        ex = exp_f(z, s);
        drive(r, z, s, id);
        #1 chk("gnt", gnt, 32'(1 << id));
        ns = n_start;
        step;
        req = 0;
        chk("gnt_pulse", gnt, 0);
        chk("busy_hi", busy, 1);
        if (byp(s)) begin
            chk("byp_valid", rsp_valid, 1);
        end else begin
            chk("au_start", au_start, 1);
            chk("au_z", au_z, z);
            chk("au_sel", au_sel, s);
        end
        wait_rsp;
        chk("rsp_id", rsp_id, id);
        chk("rsp_data", rsp_data, ex);
        chk("start_per_op", n_start - ns, byp(s) ? 0 : 1);
        man_f = 16'hBEEF;
        for (int k = 0; k < hold; k++) begin
            req = 4'hF;
            man_done = k[0];
            #1 chk("bp_gnt", gnt, 0);
            step;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, ex);
            chk("bp_id", rsp_id, id);
        end
        req = 0;
        man_done = 0;
        rsp_ready = 1;
        step;
        rsp_ready = 0;
        chk("rsp_drop", rsp_valid, 0);
        chk("busy_lo", busy, 0);
    endtask

    task automatic rnd_cycle(input bit gen);
        int e;
        op_t o;
        for (int i = 0; i < 4; i++) begin
            if (pend[i] && (!gen || $urandom_range(0, 49) == 0)) pend[i] = 0;
            else if (!pend[i] && gen && $urandom_range(0, 2) == 0) begin
                pend[i] = 1; pz[i] = 16'($urandom); ps[i] = 2'($urandom);
            end
            req[i] = pend[i];
            req_z[i*16 +: 16] = pz[i];
            req_sel[i*2 +: 2] = ps[i];
        end
        rsp_ready = gen ? ($urandom_range(0, 9) < 7) : 1'b1;
        au_lat = $urandom_range(1, 6);
        au_hold = $urandom_range(1, 3);
        #1;
        e = -1;
        if (!m_busy) for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) e = (m_ptr + k) % 4;
        chk("rr_gnt", gnt, e < 0 ? 0 : 32'(1 << e));
        chk("rr_busy", busy, m_busy);
        if (au_start && q.size() > 0) begin
            chk("rr_au_z", au_z, q[$].z);
            chk("rr_au_sel", au_sel, q[$].sel);
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) flag("unexpected_rsp");
            else begin
                o = q.pop_front();
                chk("rr_rsp_id", rsp_id, o.id);
                chk("rr_rsp_data", rsp_data, exp_f(o.z, o.sel));
            end
            m_busy = 0;
        end
        if (e >= 0) begin
            o.id = e; o.z = pz[e]; o.sel = ps[e];
            q.push_back(o);
            m_ptr = (e + 1) % 4;
            pend[e] = 0;
            m_busy = 1;
            if (!byp(ps[e])) n_nb++;
        end
        step;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, t;
        tbl[0]  = '{4'b0001, 16'h0400, 2'b00, 0};
        tbl[1]  = '{4'b1111, 16'h0155, 2'b01, 1};
        tbl[2]  = '{4'b1111, 16'hF321, 2'b00, 2};
        tbl[3]  = '{4'b1111, 16'h7ABC, 2'b10, 3};
        tbl[4]  = '{4'b1111, 16'h0001, 2'b11, 0};
        tbl[5]  = '{4'b0001, 16'h8000, 2'b01, 0};
        tbl[6]  = '{4'b1010, 16'h1234, 2'b00, 1};
        tbl[7]  = '{4'b1010, 16'h4321, 2'b01, 3};
        tbl[8]  = '{4'b0110, 16'h0FFF, 2'b00, 1};
        tbl[9]  = '{4'b1001, 16'h9000, 2'b10, 3};
        tbl[10] = '{4'b0101, 16'h0800, 2'b11, 0};
        tbl[11] = '{4'b0010, 16'hFC00, 2'b10, 1};
        tbl[12] = '{4'b1000, 16'h0800, 2'b11, 3};

        step; step;
        chk("rst_gnt", gnt, 0);
        chk("rst_au_start", au_start, 0);
        chk("rst_au_z", au_z, 0);
        chk("rst_au_sel", au_sel, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", busy, 0);
        ext_reset = 0;

        for (int i = 0; i < 13; i++) begin
            au_lat = (i == 0) ? 20 : 4;
            run_op(tbl[i].req, tbl[i].z, tbl[i].sel, tbl[i].id, (i == 1) ? 10 : 0);
        end

        // done left high from before must not be captured while in ISSUE
        man_f = 16'hDEAD;
        man_done = 1;
        au_lat = 4;
        drive(4'b0001, 16'h0123, 2'b01, 0);
        #1 chk("stale_gnt", gnt, 1);
        step;
        req = 0;
        step;
        man_done = 0;
        chk("stale_not_captured", rsp_valid, 0);
        wait_rsp;
        chk("stale_data", rsp_data, fn(16'h0123, 2'b01));
        rsp_ready = 1;
        step;
        rsp_ready = 0;

        // reset while waiting on the unit, then a late done
        au_lat = 50;
        drive(4'b0010, 16'h0222, 2'b00, 1);
        #1 chk("rw_gnt", gnt, 2);
        step;
        req = 0;
        step; step; step;
        ext_reset = 1;
        step;
        ext_reset = 0;
        cnt = 0;
        m_done = 0;
        chk("rw_valid", rsp_valid, 0);
        chk("rw_busy", busy, 0);
        chk("rw_au_z", au_z, 0);
        chk("rw_au_sel", au_sel, 0);
        chk("rw_data", rsp_data, 0);
        step; step; step;
        man_f = 16'h1234;
        man_done = 1;
        step;
        chk("late_done_valid", rsp_valid, 0);
        step;
        man_done = 0;
        chk("late_done_busy", busy, 0);
        au_lat = 4;
        run_op(4'b0101, 16'h0333, 2'b01, 0, 0);
        run_op(4'b0100, 16'h0444, 2'b00, 2, 0);

        ext_reset = 1;
        step;
        ext_reset = 0;
        cnt = 0;
        m_done = 0;
        s0 = n_start;
        repeat (3000) rnd_cycle(1);
        t = 0;
        while ((q.size() > 0 || m_busy || req != 0) && t < 300) begin rnd_cycle(0); t++; end
        if (t == 300) flag("drain_timeout");
        chk("start_count", n_start - s0, n_nb);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
